onehot_decoder: RTL and testbench

Registered binary-to-one-hot decoder with ready/valid handshaking on both sides. It is the inverse of the team's 4-to-2 encoder: a 2-bit code (by default) becomes a 4-bit one-hot word, and `en` low produces an all-zero word. A 2-entry skid buffer sits between input and output so the block can run back-to-back transfers under downstream backpressure. It sits downstream of any encoder-driven select path that needs its select lines restored.

---
 rtl/onehot_decoder_pkg.sv | 42 ++++
 rtl/onehot_decoder_skid.sv | 84 ++++++++
 rtl/onehot_decoder.sv | 108 ++++++++++
 tb/tb_onehot_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_pkg.sv
// onehot_decoder_pkg
// Shared types and helpers for the registered binary-to-one-hot decoder.
//
// Contents:
//   IN_W_DEFAULT  default code width of the decoder
//   MAX_IN_W      widest code the shared onehot() helper can decode
//   entry_t       one buffered word {code, en} at the default width
//   skid_state_t  occupancy of the 2-entry skid buffer (EMPTY, ONE, TWO)
//   onehot()      decode helper used by the RTL and by the bench model

package onehot_decoder_pkg;

    localparam int IN_W_DEFAULT = 2;
    localparam int MAX_IN_W     = 8;
    localparam int MAX_OUT_W    = 1 << MAX_IN_W;

    typedef struct packed {
        logic [IN_W_DEFAULT-1:0] code;
        logic                    en;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Decodes at the widest supported size; callers keep the low
    // (1 << their IN_W) bits. A disabled word decodes to all zeros.
    function automatic logic [MAX_OUT_W-1:0] onehot(
        input logic [MAX_IN_W-1:0] code,
        input logic                en
    );
        logic [MAX_OUT_W-1:0] word;
        word = '0;
        if (en) begin
            word[code] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/onehot_decoder_skid.sv
// onehot_decoder_skid
// Generic 2-entry ready/valid skid buffer. Words leave in arrival order,
// none are dropped or duplicated. in_ready comes straight from the state
// register, so there is no combinational path from out_ready to in_ready.
//
// Parameters:
//   T          type of one buffered word (default entry_t)
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; also holds in_ready low
//   in_valid   upstream offers in_data
//   in_ready   buffer can take a word this cycle (state != TWO)
//   in_data    word offered by upstream
//   out_valid  head word available (state != EMPTY)
//   out_ready  downstream takes the head word
//   out_data   head word, stable while out_valid && !out_ready

module onehot_decoder_skid
    import onehot_decoder_pkg::*;
#(
    parameter type T = entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    skid_state_t state;
    T            head;
    T            tail;
    logic        in_fire;
    logic        out_fire;

    assign in_ready  = !rst && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = head;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // head is always the oldest word; tail only holds a word in TWO.
    // In ONE with both transfers the head leaves and the new word takes
    // its place, so occupancy stays at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        head  <= in_data;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head <= in_data;
                    end else if (in_fire) begin
                        tail  <= in_data;
                        state <= TWO;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/onehot_decoder.sv
// onehot_decoder
// Registered binary-to-one-hot decoder with ready/valid on both sides.
// Each accepted {in_code, in_en} is stored in a 2-entry skid buffer and
// decoded from the buffer head, so out_onehot is stable under backpressure.
// in_en = 0 yields an all-zero word.
//
// Optional feature: define ONEHOT_DECODER_HIST_EN to add per-output
// saturating histogram counters (hist_clr, hist_count, parameter CNT_W).
//
// Parameters:
//   IN_W        code width (up to MAX_IN_W); OUT_W = 1 << IN_W is derived
//   CNT_W       histogram counter width (ONEHOT_DECODER_HIST_EN only)
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    input word offered
//   in_ready    block can accept a word this cycle
//   in_code     binary code to decode
//   in_en       decode enable sampled with in_code
//   out_valid   decoded word available
//   out_ready   downstream accepts the word
//   out_onehot  decoded word
//   hist_clr    clears all counters (ONEHOT_DECODER_HIST_EN only)
//   hist_count  counter i at [i*CNT_W +: CNT_W] (ONEHOT_DECODER_HIST_EN only)

module onehot_decoder
    import onehot_decoder_pkg::*;
#(
    parameter int IN_W = IN_W_DEFAULT
`ifdef ONEHOT_DECODER_HIST_EN
    ,
    parameter int CNT_W = 8
`endif
    ,
    localparam int OUT_W = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot
`ifdef ONEHOT_DECODER_HIST_EN
    ,
    input  logic                   hist_clr,
    output logic [OUT_W*CNT_W-1:0] hist_count
`endif
);

    typedef struct packed {
        logic [IN_W-1:0] code;
        logic            en;
    } word_t;

    word_t in_word;
    word_t head_word;

    assign in_word = {in_code, in_en};

    onehot_decoder_skid #(
        .T(word_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_word)
    );

    // Decode is purely from the registered head; gating with out_valid keeps
    // the output at zero when the buffer is empty instead of showing the
    // last word that left.
    assign out_onehot = out_valid
                      ? OUT_W'(onehot(MAX_IN_W'(head_word.code), head_word.en))
                      : '0;

`ifdef ONEHOT_DECODER_HIST_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                             out_fire;
    logic [OUT_W-1:0][CNT_W-1:0]      counts;

    assign out_fire   = out_valid && out_ready;
    assign hist_count = counts;

    // Count each output transfer against its set bit. All-zero words touch
    // nothing, counters stop at all-ones, and a clear wins over an
    // increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || hist_clr) begin
            counts <= '0;
        end else if (out_fire) begin
            for (int i = 0; i < OUT_W; i++) begin
                if (out_onehot[i] && (counts[i] != CNT_MAX)) begin
                    counts[i] <= counts[i] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_onehot_decoder.sv
// tb_onehot_decoder
// Self-checking bench for onehot_decoder (IN_W = 2). A queue-based model
// of the buffer tracks which words are waiting and in what order; a table
// of vectors covers the streaming and backpressure scenarios, hand-written
// sequences cover reset in TWO and sustained pass-through in ONE, and a
// random phase exercises everything against the model. With
// ONEHOT_DECODER_HIST_EN defined the counters (CNT_W = 2) are also checked.

module tb_onehot_decoder;

    localparam int TB_CNT_W = 2;
    localparam int TB_CNT_MAX = (1 << TB_CNT_W) - 1;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic       in_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_onehot;
`ifdef ONEHOT_DECODER_HIST_EN
    logic       hist_clr;
    logic [7:0] hist_count;
    int         hist_m [4];
`endif

    int check_count = 0;
    int pass_count  = 0;

    logic [3:0] model_q [$];

    typedef struct {
        logic       v;
        logic [1:0] code;
        logic       en;
        logic       ordy;
        logic       exp_ready;
        logic       exp_valid;
        logic [3:0] exp_onehot;
    } vec_t;

    vec_t vecs [13];

`ifdef ONEHOT_DECODER_HIST_EN
    onehot_decoder #(.IN_W(2), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .hist_clr   (hist_clr),
        .hist_count (hist_count)
    );
`else
    onehot_decoder #(.IN_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected decoded word from the plain rule: bit code set when enabled.
    function automatic logic [3:0] expectWord(input logic [1:0] code, input logic en);
        return en ? (4'b0001 << code) : 4'b0000;
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the rising edge
    // and leave the bench 1 time unit after that edge.
    task automatic applyStimulus(input logic v, input logic [1:0] c, input logic e, input logic r);
        logic m_in_fire;
        logic m_out_fire;
        in_valid  = v;
        in_code   = c;
        in_en     = e;
        out_ready = r;
        m_in_fire  = v && !rst && (model_q.size() < 2);
        m_out_fire = r && (model_q.size() > 0);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
`ifdef ONEHOT_DECODER_HIST_EN
            foreach (hist_m[i]) hist_m[i] = 0;
`endif
        end else begin
`ifdef ONEHOT_DECODER_HIST_EN
            if (hist_clr) begin
                foreach (hist_m[i]) hist_m[i] = 0;
            end else if (m_out_fire) begin
                for (int i = 0; i < 4; i++) begin
                    if (model_q[0][i] && hist_m[i] < TB_CNT_MAX) hist_m[i]++;
                end
            end
`endif
            if (m_out_fire) void'(model_q.pop_front());
            if (m_in_fire) model_q.push_back(expectWord(c, e));
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] exp_word;
        exp_word = (model_q.size() > 0) ? model_q[0] : 4'b0000;
        compare({tag, ".in_ready"},   64'(in_ready),   64'(!rst && model_q.size() < 2));
        compare({tag, ".out_valid"},  64'(out_valid),  64'(model_q.size() > 0));
        compare({tag, ".out_onehot"}, 64'(out_onehot), 64'(exp_word));
`ifdef ONEHOT_DECODER_HIST_EN
        for (int i = 0; i < 4; i++) begin
            compare($sformatf("%s.hist%0d", tag, i),
                    64'(hist_count[i*TB_CNT_W +: TB_CNT_W]), 64'(hist_m[i]));
        end
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
            checkOutput("drain");
        end
    endtask

    initial begin
        // {v, code, en, ordy} -> {in_ready, out_valid, out_onehot} after the edge
        vecs[0]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000};
        vecs[1]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100};
        vecs[2]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0010};
        vecs[3]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[7]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010};
        vecs[8]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010};
        vecs[9]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010};
        vecs[10] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000};
        vecs[11] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        in_en     = 1'b0;
        out_ready = 1'b0;
`ifdef ONEHOT_DECODER_HIST_EN
        hist_clr  = 1'b0;
        foreach (hist_m[i]) hist_m[i] = 0;
`endif

        repeat (3) @(posedge clk);
        #1;
        compare("reset.in_ready",   64'(in_ready),   64'(0));
        compare("reset.out_valid",  64'(out_valid),  64'(0));
        compare("reset.out_onehot", 64'(out_onehot), 64'(0));
        checkOutput("reset");
        rst = 1'b0;
        #1;
        compare("post_reset.in_ready", 64'(in_ready), 64'(1));

        // Streaming, en=0 and backpressure vectors
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].v, vecs[i].code, vecs[i].en, vecs[i].ordy);
            compare($sformatf("tbl%0d.in_ready", i),   64'(in_ready),   64'(vecs[i].exp_ready));
            compare($sformatf("tbl%0d.out_valid", i),  64'(out_valid),  64'(vecs[i].exp_valid));
            compare($sformatf("tbl%0d.out_onehot", i), 64'(out_onehot), 64'(vecs[i].exp_onehot));
            checkOutput($sformatf("tbl%0d", i));
        end

        // Sustained simultaneous transfers while holding one word
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        checkOutput("one_load");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 2'd1, 1'b1, 1'b1);
            compare($sformatf("one%0d.in_ready", i),   64'(in_ready),   64'(1));
            compare($sformatf("one%0d.out_onehot", i), 64'(out_onehot), 64'(4'b0010));
            checkOutput($sformatf("one%0d", i));
        end
        drain();

        // Reset while two words are buffered
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
        compare("two.in_ready", 64'(in_ready), 64'(0));
        checkOutput("two");
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        compare("rst_two.out_valid",  64'(out_valid),  64'(0));
        compare("rst_two.out_onehot", 64'(out_onehot), 64'(0));
        compare("rst_two.in_ready",   64'(in_ready),   64'(0));
        rst = 1'b0;
        #1;
        compare("rst_two_rel.in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
            compare($sformatf("no_stale%0d.out_valid", i), 64'(out_valid), 64'(0));
            checkOutput("no_stale");
        end

        // Random traffic, with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) != 0));
            checkOutput($sformatf("rnd%0d", i));
        end
        rst = 1'b0;
        #1;
        drain();

`ifdef ONEHOT_DECODER_HIST_EN
        // Saturation and clear-beats-increment
        hist_clr = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        hist_clr = 1'b0;
        checkOutput("hist_clr");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b1, 1'b1);
            checkOutput("hist_sat");
        end
        drain();
        compare("hist_sat.count0", 64'(hist_count[1:0]), 64'(3));
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        checkOutput("hist_load");
        hist_clr = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        hist_clr = 1'b0;
        compare("hist_clr_wins.count0", 64'(hist_count[1:0]), 64'(0));
        checkOutput("hist_clr_wins");
`endif

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
